screen_sequencer: RTL and testbench
===================================

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 5: width of the screen index and total_screens.
REQ-002 SHALL have parameter SEC_CYCLES, default 50000000: clock cycles per elapsed second.
REQ-003 SHALL have parameters TITLE_CYCLES 12500000, TRACE_CYCLES 500000000 and MSG_CYCLES 250000000: dwell per screen type, each >= 1.
REQ-004 SHALL have parameter REPLAY_CYCLES, default 200000000: dwell on the end screen before restart.
REQ-005 SHALL have parameter TIME_W, default 32: width of time_out.
REQ-006 clock  input  1  system clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 total_screens  input  SCREEN_W  screen count; latched at game start.
REQ-009 pause  input  1  level; freezes dwell and second counters.
REQ-010 skip  input  1  single-cycle pulse; ends the current screen early.
REQ-011 curr_screen  output  SCREEN_W  current screen, 1-based.
REQ-012 time_out  output  TIME_W  whole seconds elapsed in the current game.
REQ-013 end_of_game  output  1  high while in END.
REQ-014 play_again  output  1  one-cycle pulse at restart.
REQ-015 snitch_powerup  output  1  power-up window flag.

Function
REQ-016 SHALL implement FSM states TITLE, TRACE, MSG and END.
REQ-017 Screen 1 SHALL be TITLE; even screens below total SHALL be TRACE; odd screens above 1 and below total SHALL be MSG; screen == total SHALL be END.
REQ-018 A non-END screen SHALL last exactly its dwell in unpaused cycles, after which curr_screen increments on the following edge.
REQ-019 The dwell counter SHALL clear on every screen change.
REQ-020 skip SHALL advance the screen on the next edge, even while paused.
REQ-021 skip coinciding with dwell expiry SHALL advance the screen exactly once.
REQ-022 skip in END SHALL be ignored.
REQ-023 A latched total below 2 SHALL put the block in END with curr_screen = 1.
REQ-024 end_of_game SHALL be registered and high in exactly the cycles in which state is END.
REQ-025 After REPLAY_CYCLES unpaused cycles in END, the block SHALL pulse play_again for one cycle and in that same edge set curr_screen = 1, clear time_out and relatch total_screens.
REQ-026 time_out SHALL increment once per SEC_CYCLES unpaused cycles.
REQ-027 time_out SHALL saturate at all-ones and SHALL hold its value in END.
REQ-028 Counter widths SHALL be derived from the parameters with $clog2; no arithmetic SHALL wrap.

Reset
REQ-029 Reset SHALL force state TITLE, curr_screen = 1, time_out = 0 and every other output 0.
REQ-030 Reset SHALL clear all counters and latch total_screens on the first edge after release.
REQ-031 Reset mid-game SHALL abort immediately with no play_again pulse.

Configuration
REQ-032 With SNITCH_POWERUP_EN defined, snitch_powerup SHALL be high in TRACE while the per-screen second count is in [SNITCH_LO, SNITCH_HI), parameters defaulting to 8 and 15.
REQ-033 With SNITCH_POWERUP_EN defined, snitch_powerup SHALL be low in every other state.
REQ-034 Without SNITCH_POWERUP_EN, snitch_powerup SHALL be tied 0 and the per-screen second counter SHALL be absent.

Structure
REQ-035 Package screen_pkg SHALL hold the FSM state enum and the default dwell constants.
REQ-036 Sub-module sec_tick SHALL be a pausable divide-by-SEC_CYCLES one-cycle pulse generator, instantiated once.

Verification (SEC_CYCLES=4, TITLE=3, TRACE=5, MSG=2, REPLAY=6, total_screens=4)
REQ-037 Release reset, no pause or skip: curr_screen 1 for 3 cycles, 2 for 5, 3 for 2, then 4 with end_of_game=1.
REQ-038 Continuing: after 6 cycles in END, play_again high for one cycle, curr_screen=1, time_out=0, end_of_game=0.
REQ-039 Pause held 10 cycles during screen 2: curr_screen and time_out frozen; 5 total unpaused cycles on screen 2.
REQ-040 skip on the dwell-expiry cycle of screen 2: curr_screen goes to 3, never 4, on the next edge.
REQ-041 total_screens=1 at reset release: end_of_game=1 from the first edge; skip ignored; play_again after 6 cycles.
REQ-042 Reset asserted mid-screen 3: outputs clear asynchronously; no play_again pulse observed.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared FSM state type and default dwell constants for the screen sequencer.
// Optional feature macro used by the top: SNITCH_POWERUP_EN.
package screen_pkg;

   typedef enum logic [1:0] {
      S_TITLE,
      S_TRACE,
      S_MSG,
      S_END
   } screen_state_t;

   localparam int DEF_SEC_CYCLES    = 50000000;
   localparam int DEF_TITLE_CYCLES  = 12500000;
   localparam int DEF_TRACE_CYCLES  = 500000000;
   localparam int DEF_MSG_CYCLES    = 250000000;
   localparam int DEF_REPLAY_CYCLES = 200000000;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/screen_sequencer_sec_tick.sv
// Pausable divide-by-SEC_CYCLES generator: one-cycle tick every SEC_CYCLES enabled cycles.
module sec_tick
   import screen_pkg::*;
#(
   parameter int SEC_CYCLES = DEF_SEC_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int W = $clog2(SEC_CYCLES + 1);

   logic [W-1:0] cnt;

   assign tick = enable && (cnt == W'(SEC_CYCLES - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/screen_sequencer.sv
// Game screen sequencer: TITLE/TRACE/MSG/END dwell FSM with elapsed-seconds counter.
// Define SNITCH_POWERUP_EN to enable the per-screen snitch power-up window.
module screen_sequencer
   import screen_pkg::*;
#(
   parameter int SCREEN_W      = 5,
   parameter int SEC_CYCLES    = DEF_SEC_CYCLES,
   parameter int TITLE_CYCLES  = DEF_TITLE_CYCLES,
   parameter int TRACE_CYCLES  = DEF_TRACE_CYCLES,
   parameter int MSG_CYCLES    = DEF_MSG_CYCLES,
   parameter int REPLAY_CYCLES = DEF_REPLAY_CYCLES,
   parameter int TIME_W        = 32
`ifdef SNITCH_POWERUP_EN
   ,
   parameter int SNITCH_LO     = 8,
   parameter int SNITCH_HI     = 15
`endif
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [SCREEN_W-1:0] total_screens,
   input  logic                pause,
   input  logic                skip,
   output logic [SCREEN_W-1:0] curr_screen,
   output logic [TIME_W-1:0]   time_out,
   output logic                end_of_game,
   output logic                play_again,
   output logic                snitch_powerup
);

   localparam int MAX_DWELL = max_of(max_of(TITLE_CYCLES, TRACE_CYCLES),
                                     max_of(MSG_CYCLES, REPLAY_CYCLES));
   localparam int CNT_W     = $clog2(MAX_DWELL + 1);

   screen_state_t       state;
   screen_state_t       nxt_state;
   logic                started;
   logic [SCREEN_W-1:0] total_lat;
   logic [SCREEN_W-1:0] nxt_screen;
   logic [CNT_W-1:0]    dwell_cnt;
   logic [CNT_W-1:0]    dwell_last;
   logic                expired;
   logic                restart;
   logic                advance;
   logic                sec_en;
   logic                sec_pulse;

   // restart covers both the first edge after reset and the END replay timeout
   always_comb begin
      dwell_last = CNT_W'(TITLE_CYCLES - 1);
      unique case (state)
         S_TRACE: dwell_last = CNT_W'(TRACE_CYCLES - 1);
         S_MSG:   dwell_last = CNT_W'(MSG_CYCLES - 1);
         S_END:   dwell_last = CNT_W'(REPLAY_CYCLES - 1);
         default: dwell_last = CNT_W'(TITLE_CYCLES - 1);
      endcase
      expired    = !pause && (dwell_cnt == dwell_last);
      restart    = !started || ((state == S_END) && expired);
      advance    = started && (state != S_END) && (skip || expired);
      nxt_screen = curr_screen + SCREEN_W'(1);
      nxt_state  = S_TRACE;
      if (nxt_screen == total_lat) begin
         nxt_state = S_END;
      end else if (nxt_screen[0]) begin
         nxt_state = S_MSG;
      end
   end

   assign sec_en = started && !pause && (state != S_END);

   sec_tick #(
      .SEC_CYCLES(SEC_CYCLES)
   ) u_sec_tick (
      .clock (clock),
      .reset (reset),
      .clear (restart),
      .enable(sec_en),
      .tick  (sec_pulse)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_TITLE;
         started     <= 1'b0;
         total_lat   <= '0;
         curr_screen <= SCREEN_W'(1);
         dwell_cnt   <= '0;
         time_out    <= '0;
         end_of_game <= 1'b0;
         play_again  <= 1'b0;
      end else begin
         play_again <= 1'b0;
         if (restart) begin
            started     <= 1'b1;
            total_lat   <= total_screens;
            curr_screen <= SCREEN_W'(1);
            dwell_cnt   <= '0;
            play_again  <= started;
            if (total_screens < SCREEN_W'(2)) begin
               state       <= S_END;
               end_of_game <= 1'b1;
            end else begin
               state       <= S_TITLE;
               end_of_game <= 1'b0;
            end
         end else if (advance) begin
            curr_screen <= nxt_screen;
            state       <= nxt_state;
            end_of_game <= (nxt_state == S_END);
            dwell_cnt   <= '0;
         end else if (!pause) begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
         end

         if (restart) begin
            time_out <= '0;
         end else if (sec_pulse && (time_out != '1)) begin
            time_out <= time_out + TIME_W'(1);
         end
      end
   end

`ifdef SNITCH_POWERUP_EN
   localparam int SS_W = $clog2(SNITCH_HI + 1);

   logic [SS_W-1:0] scr_sec;
   logic [SS_W-1:0] scr_sec_nxt;
   screen_state_t   state_nxt;

   // Follows the FSM's next state so the flag drops in the same edge TRACE is left
   always_comb begin
      state_nxt   = state;
      scr_sec_nxt = scr_sec;
      if (restart) begin
         state_nxt   = (total_screens < SCREEN_W'(2)) ? S_END : S_TITLE;
         scr_sec_nxt = '0;
      end else if (advance) begin
         state_nxt   = nxt_state;
         scr_sec_nxt = '0;
      end else if (sec_pulse && (scr_sec != SS_W'(SNITCH_HI))) begin
         scr_sec_nxt = scr_sec + SS_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scr_sec        <= '0;
         snitch_powerup <= 1'b0;
      end else begin
         scr_sec        <= scr_sec_nxt;
         snitch_powerup <= (state_nxt == S_TRACE) &&
                           (scr_sec_nxt >= SS_W'(SNITCH_LO)) &&
                           (scr_sec_nxt < SS_W'(SNITCH_HI));
      end
   end
`else
   assign snitch_powerup = 1'b0;
`endif

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_screen_sequencer;

   localparam int SCREEN_W = 5;
   localparam int TIME_W   = 3;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic [SCREEN_W-1:0] total_screens = 5'd4;
   logic                pause = 1'b0;
   logic                skip  = 1'b0;
   logic [SCREEN_W-1:0] curr_screen;
   logic [TIME_W-1:0]   time_out;
   logic                end_of_game;
   logic                play_again;
   logic                snitch_powerup;

   typedef struct packed {
      logic [SCREEN_W-1:0] curr;
      logic [TIME_W-1:0]   tm;
      logic                eog;
      logic                pa;
      logic                snitch;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    passes = 0;

   screen_sequencer #(
      .SCREEN_W     (SCREEN_W),
      .SEC_CYCLES   (4),
      .TITLE_CYCLES (3),
      .TRACE_CYCLES (5),
      .MSG_CYCLES   (2),
      .REPLAY_CYCLES(6),
      .TIME_W       (TIME_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .total_screens (total_screens),
      .pause         (pause),
      .skip          (skip),
      .curr_screen   (curr_screen),
      .time_out      (time_out),
      .end_of_game   (end_of_game),
      .play_again    (play_again),
      .snitch_powerup(snitch_powerup)
   );

   always #5 clock = ~clock;

   task automatic push_exp(input string name, input int c, input int t,
                           input bit eog, input bit pa);
      exp_t e;
      e.curr   = SCREEN_W'(c);
      e.tm     = TIME_W'(t);
      e.eog    = eog;
      e.pa     = pa;
      e.snitch = 1'b0;
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // Drive inputs for the coming edge, then record what must be visible after it
   task automatic applyStimulus(input bit p, input bit s, input string name,
                                input int c, input int t, input bit eog, input bit pa);
      pause = p;
      skip  = s;
      @(posedge clock);
      #1;
      pause = 1'b0;
      skip  = 1'b0;
      push_exp(name, c, t, eog, pa);
   endtask

   task automatic checkOutput(input string name, input exp_t e);
      checks++;
      if (curr_screen === e.curr && time_out === e.tm && end_of_game === e.eog &&
          play_again === e.pa && snitch_powerup === e.snitch) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s @%0t: got curr=%0d time=%0d eog=%0b pa=%0b snitch=%0b, want curr=%0d time=%0d eog=%0b pa=%0b snitch=%0b",
                  name, $time, curr_screen, time_out, end_of_game, play_again, snitch_powerup,
                  e.curr, e.tm, e.eog, e.pa, e.snitch);
      end
   endtask

   always @(negedge clock) begin : monitor
      exp_t  e;
      string n;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         checkOutput(n, e);
      end
   end

   initial begin
      #1;
      push_exp("reset", 1, 0, 0, 0);
      @(posedge clock);
      #1 reset = 1'b0;

      // Two back-to-back games with total 4: 3 + 5 + 2 cycles, then 6 in END
      for (int r = 0; r < 20; r++) begin
         int c;
         int t;
         c = (r < 3) ? 1 : (r < 8) ? 2 : (r < 10) ? 3 : (r < 16) ? 4 : (r < 19) ? 1 : 2;
         t = (r < 4) ? 0 : (r < 8) ? 1 : (r < 16) ? 2 : 0;
         applyStimulus(0, 0, "game", c, t, (r >= 10 && r < 16), (r == 16));
      end

      repeat (10) applyStimulus(1, 0, "pause_freeze", 2, 0, 0, 0);
      repeat (4)  applyStimulus(0, 0, "unpause", 2, 1, 0, 0);
      applyStimulus(0, 0, "pause_adv", 3, 2, 0, 0);
      applyStimulus(0, 0, "msg", 3, 2, 0, 0);
      applyStimulus(0, 0, "end", 4, 2, 1, 0);
      applyStimulus(0, 1, "end_skip", 4, 2, 1, 0);
      repeat (4) applyStimulus(0, 0, "end_hold", 4, 2, 1, 0);
      applyStimulus(0, 0, "replay", 1, 0, 0, 1);

      applyStimulus(0, 0, "g3_title", 1, 0, 0, 0);
      applyStimulus(0, 0, "g3_title", 1, 0, 0, 0);
      applyStimulus(0, 0, "g3_trace", 2, 0, 0, 0);
      repeat (4) applyStimulus(0, 0, "g3_trace", 2, 1, 0, 0);
      applyStimulus(0, 1, "skip_on_expiry", 3, 2, 0, 0);
      applyStimulus(1, 1, "skip_paused", 4, 2, 1, 0);
      repeat (5) applyStimulus(0, 0, "g3_end", 4, 2, 1, 0);
      applyStimulus(0, 0, "g3_replay", 1, 0, 0, 1);

      applyStimulus(0, 0, "g4", 1, 0, 0, 0);
      applyStimulus(0, 0, "g4", 1, 0, 0, 0);
      applyStimulus(0, 0, "g4", 2, 0, 0, 0);
      repeat (4) applyStimulus(0, 0, "g4", 2, 1, 0, 0);
      applyStimulus(0, 0, "g4_msg", 3, 2, 0, 0);

      // Asynchronous reset in the middle of screen 3
      @(posedge clock);
      #2 reset = 1'b1;
      push_exp("reset_mid", 1, 0, 0, 0);
      repeat (2) begin
         @(posedge clock);
         #1 push_exp("reset_hold", 1, 0, 0, 0);
      end
      total_screens = 5'd1;
      @(posedge clock);
      #1 reset = 1'b0;

      applyStimulus(0, 0, "short", 1, 0, 1, 0);
      applyStimulus(0, 1, "short_skip", 1, 0, 1, 0);
      repeat (4) applyStimulus(0, 0, "short_end", 1, 0, 1, 0);
      applyStimulus(0, 0, "short_replay", 1, 0, 1, 1);
      applyStimulus(0, 0, "short_after", 1, 0, 1, 0);

      // Long game of 12 screens: 38 cycles to END, enough seconds to saturate 3 bits
      @(posedge clock);
      #1 reset = 1'b1;
      total_screens = 5'd12;
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (38) @(posedge clock);
      applyStimulus(0, 0, "saturate", 12, 7, 1, 0);
      repeat (2) applyStimulus(0, 0, "saturate_hold", 12, 7, 1, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         $display("[TB] FAIL drain: pending=%0d required=0", exp_q.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
